// File: rtl/microseq_controller.sv
// -----------------------------------------------------------------------------
// microseq_controller
//
// Micro-sequenced controller for the X/Y/Z register blocks and the ALU.
// Instructions arrive over a valid/ready handshake. Single-step opcodes issue
// one registered control word. The REP_ADD macro-op issues rep+1 consecutive
// ADD words. The MUL macro-op issues MUL_ITER add/shift pairs, and the add
// half of each pair loads Y only when y_lsb is set.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   instr_valid  instruction present on opcode/rep
//   instr_ready  controller can accept (combinational, state == IDLE)
//   opcode       instruction opcode (OP_W bits)
//   rep          REP_ADD repeat count (CNT_W bits), issues rep+1 adds
//   y_lsb        current LSB of Y, sampled in the add half of a MUL step
//   Tx/Ty/Tz     register control words: HOLD=0, LOAD=1, CLEAR=2, SHR=3
//   Tula         ALU select: 0 = add, 1 = pass X
//   busy         macro-op in progress
//   done         pulse on the final control word of any legal instruction
//   illegal      pulse for an unrecognised opcode
// -----------------------------------------------------------------------------
module microseq_controller #(
    parameter int OP_W     = 4,
    parameter int CTL_W    = 4,
    parameter int CNT_W    = 4,
    parameter int MUL_ITER = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic [CNT_W-1:0] rep,
    input  logic             y_lsb,
    output logic [CTL_W-1:0] Tx,
    output logic [CTL_W-1:0] Ty,
    output logic [CTL_W-1:0] Tz,
    output logic             Tula,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    localparam int IT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

    localparam logic [CTL_W-1:0] C_HOLD  = CTL_W'(0);
    localparam logic [CTL_W-1:0] C_LOAD  = CTL_W'(1);
    localparam logic [CTL_W-1:0] C_CLEAR = CTL_W'(2);
    localparam logic [CTL_W-1:0] C_SHR   = CTL_W'(3);

    localparam logic [OP_W-1:0] OP_CLEAR_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD_LOAD    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD         = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SHIFT_RIGHT = OP_W'(3);
    localparam logic [OP_W-1:0] OP_DISP        = OP_W'(4);
    localparam logic [OP_W-1:0] OP_REP_ADD     = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MUL         = OP_W'(6);

    localparam logic [IT_W-1:0] IT_LAST = IT_W'(MUL_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REP,
        S_M_ADD,
        S_M_SHR
    } state_e;

    // One registered control word: Tx, Ty, Tz and ALU select.
    typedef struct packed {
        logic [CTL_W-1:0] tx;
        logic [CTL_W-1:0] ty;
        logic [CTL_W-1:0] tz;
        logic             tula;
    } word_t;

    localparam word_t W_IDLE      = '{C_HOLD,  C_HOLD,  C_HOLD,  1'b0};
    localparam word_t W_CLEAR_ADD = '{C_LOAD,  C_CLEAR, C_CLEAR, 1'b1};
    localparam word_t W_ADD_LOAD  = '{C_LOAD,  C_LOAD,  C_HOLD,  1'b0};
    localparam word_t W_ADD       = '{C_HOLD,  C_LOAD,  C_HOLD,  1'b0};
    localparam word_t W_SHR       = '{C_HOLD,  C_SHR,   C_HOLD,  1'b1};
    localparam word_t W_DISP      = '{C_CLEAR, C_CLEAR, C_LOAD,  1'b0};

    state_e           state_q,   state_d;
    word_t            word_q,    word_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [IT_W-1:0]  it_q,      it_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             illegal_q, illegal_d;

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned; that is what keeps this block latch-free.
    always_comb begin
        state_d   = state_q;
        word_d    = W_IDLE;
        cnt_d     = cnt_q;
        it_d      = it_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // instr_ready is 1 in IDLE, so valid alone means accept.
                if (instr_valid) begin
                    case (opcode)
                        OP_CLEAR_ADD:   begin word_d = W_CLEAR_ADD; done_d = 1'b1; end
                        OP_ADD_LOAD:    begin word_d = W_ADD_LOAD;  done_d = 1'b1; end
                        OP_ADD:         begin word_d = W_ADD;       done_d = 1'b1; end
                        OP_SHIFT_RIGHT: begin word_d = W_SHR;       done_d = 1'b1; end
                        OP_DISP:        begin word_d = W_DISP;      done_d = 1'b1; end
                        OP_REP_ADD: begin
                            word_d = W_ADD;
                            cnt_d  = rep;
                            if (rep == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = S_REP;
                            end
                        end
                        OP_MUL: begin
                            // Accept cycle issues nothing; the first add
                            // half follows in M_ADD.
                            it_d    = IT_LAST;
                            state_d = S_M_ADD;
                        end
                        default: illegal_d = 1'b1;
                    endcase
                end
            end

            S_REP: begin
                word_d = W_ADD;
                cnt_d  = cnt_q - CNT_W'(1);
                // The word that takes cnt to zero is the last one.
                if (cnt_q == CNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_M_ADD: begin
                word_d    = W_ADD;
                word_d.ty = y_lsb ? C_LOAD : C_HOLD;
                state_d   = S_M_SHR;
            end

            S_M_SHR: begin
                word_d = W_SHR;
                if (it_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    it_d    = it_q - IT_W'(1);
                    state_d = S_M_ADD;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // busy is registered alongside the word, so it is high exactly while the
    // registered state is a macro-op state.
    assign busy_d = (state_d != S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            word_q    <= W_IDLE;
            cnt_q     <= '0;
            it_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            cnt_q     <= cnt_d;
            it_q      <= it_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign Tx          = word_q.tx;
    assign Ty          = word_q.ty;
    assign Tz          = word_q.tz;
    assign Tula        = word_q.tula;
    assign busy        = busy_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_microseq_controller.sv
// -----------------------------------------------------------------------------
// tb_microseq_controller
//
// Self-checking bench for microseq_controller. The reference model expands
// each accepted instruction into a queue of per-cycle output slots. One slot
// is popped at every rising edge, and that slot is what the outputs must show
// in the following cycle. While the queue is non-empty, the model expects the
// controller to refuse new instructions.
// -----------------------------------------------------------------------------
module tb_microseq_controller;

    localparam int OP_W     = 4;
    localparam int CTL_W    = 4;
    localparam int CNT_W    = 4;
    localparam int MUL_ITER = 8;

    localparam int HD = 0;
    localparam int LD = 1;
    localparam int CL = 2;
    localparam int SR = 3;

    logic             clock       = 1'b0;
    logic             reset_n     = 1'b1;
    logic             instr_valid = 1'b0;
    logic [OP_W-1:0]  opcode      = '0;
    logic [CNT_W-1:0] rep         = '0;
    logic             y_lsb       = 1'b0;
    logic             instr_ready;
    logic [CTL_W-1:0] Tx, Ty, Tz;
    logic             Tula, busy, done, illegal;

    microseq_controller #(
        .OP_W(OP_W), .CTL_W(CTL_W), .CNT_W(CNT_W), .MUL_ITER(MUL_ITER)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .opcode     (opcode),
        .rep        (rep),
        .y_lsb      (y_lsb),
        .Tx         (Tx),
        .Ty         (Ty),
        .Tz         (Tz),
        .Tula       (Tula),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] tx, ty, tz;
        logic       tula, busy, done, illegal;
        logic       mul_add;  // Ty resolved from y_lsb at the issuing edge
    } slot_t;

    slot_t      q[$];
    slot_t      cur;
    logic       exp_ready = 1'b1;
    logic       acc_now   = 1'b0;
    int         acc_op    = 0;
    int         checks    = 0;
    int         errors    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %05h expected %05h (Tx,Ty,Tz,Tula,busy,done,illegal,ready)",
                     tag, $time, obs, exp);
        end
    endtask

    function automatic slot_t mk(int tx, int ty, int tz, bit tula, bit bsy, bit dn, bit ill, bit madd);
        slot_t s;
        s.tx = 4'(tx); s.ty = 4'(ty); s.tz = 4'(tz);
        s.tula = tula; s.busy = bsy; s.done = dn; s.illegal = ill; s.mul_add = madd;
        return s;
    endfunction

    function automatic logic [31:0] obs_vec();
        return 32'({Tx, Ty, Tz, Tula, busy, done, illegal, instr_ready});
    endfunction

    function automatic logic [31:0] exp_vec();
        return 32'({cur.tx, cur.ty, cur.tz, cur.tula, cur.busy, cur.done, cur.illegal, exp_ready});
    endfunction

    // Expand one accepted instruction into its per-cycle output slots.
    task automatic expand(input int op, input int r);
        case (op)
            0: q.push_back(mk(LD, CL, CL, 1, 0, 1, 0, 0));
            1: q.push_back(mk(LD, LD, HD, 0, 0, 1, 0, 0));
            2: q.push_back(mk(HD, LD, HD, 0, 0, 1, 0, 0));
            3: q.push_back(mk(HD, SR, HD, 1, 0, 1, 0, 0));
            4: q.push_back(mk(CL, CL, LD, 0, 0, 1, 0, 0));
            5: for (int i = 0; i <= r; i++)
                   q.push_back(mk(HD, LD, HD, 0, i < r, i == r, 0, 0));
            6: begin
                q.push_back(mk(HD, HD, HD, 0, 1, 0, 0, 0));
                for (int k = 0; k < MUL_ITER; k++) begin
                    q.push_back(mk(HD, HD, HD, 0, 1, 0, 0, 1));
                    q.push_back(mk(HD, SR, HD, 1, k < MUL_ITER - 1, k == MUL_ITER - 1, 0, 0));
                end
            end
            default: q.push_back(mk(HD, HD, HD, 0, 0, 0, 1, 0));
        endcase
    endtask

    // Model behaviour at one rising edge, from the inputs driven before it.
    task automatic model_edge();
        acc_now = 1'b0;
        if (!reset_n) begin
            q.delete();
            cur       = mk(HD, HD, HD, 0, 0, 0, 0, 0);
            exp_ready = 1'b1;
            return;
        end
        if (q.size() == 0 && instr_valid) begin
            acc_now = 1'b1;
            acc_op  = int'(opcode);
            expand(int'(opcode), int'(rep));
        end
        if (q.size() > 0) begin
            cur = q.pop_front();
            if (cur.mul_add) cur.ty = y_lsb ? 4'(LD) : 4'(HD);
        end else begin
            cur = mk(HD, HD, HD, 0, 0, 0, 0, 0);
        end
        exp_ready = (q.size() == 0);
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check(tag, obs_vec(), exp_vec());
    endtask

    logic mul_pat [MUL_ITER] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        cur = mk(HD, HD, HD, 0, 0, 0, 0, 0);

        // Power-on reset.
        #1 reset_n = 1'b0;
        #1 check("reset", obs_vec(), exp_vec());
        step("reset_hold");
        reset_n = 1'b1;
        step("idle");

        // Back-to-back single-step opcodes.
        for (int op = 0; op < 5; op++) begin
            instr_valid = 1'b1;
            opcode      = OP_W'(op);
            step("single");
        end
        instr_valid = 1'b0;
        step("single_end");

        // REP_ADD rep=0, then rep=3.
        instr_valid = 1'b1; opcode = OP_W'(5); rep = '0;
        step("rep0");
        instr_valid = 1'b0;
        step("rep0_end");
        instr_valid = 1'b1; rep = CNT_W'(3);
        step("rep3");
        instr_valid = 1'b0;
        for (int i = 0; i < 4; i++) step("rep3");

        // MUL with a fixed y_lsb pattern.
        instr_valid = 1'b1; opcode = OP_W'(6);
        step("mul_acc");
        instr_valid = 1'b0;
        for (int k = 0; k < MUL_ITER; k++) begin
            y_lsb = mul_pat[k];
            step("mul_add");
            y_lsb = 1'($urandom);
            step("mul_shr");
        end
        step("mul_end");

        // Illegal opcodes, then an immediate legal one.
        instr_valid = 1'b1; opcode = OP_W'(7);
        step("illegal7");
        opcode = OP_W'(15);
        step("illegal15");
        opcode = OP_W'(2);
        step("after_illegal");
        instr_valid = 1'b0;
        step("after_illegal_end");

        // ADD held valid throughout a MUL until accepted.
        instr_valid = 1'b1; opcode = OP_W'(6);
        step("held_mul");
        opcode = OP_W'(2);
        for (int i = 0; i < 2 * MUL_ITER + 3; i++) begin
            y_lsb = 1'($urandom);
            step("held_add");
            if (acc_now && acc_op == 2) instr_valid = 1'b0;
        end

        // Reset asserted during the third MUL iteration.
        instr_valid = 1'b1; opcode = OP_W'(6);
        step("rst_mul_acc");
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            y_lsb = 1'b1;
            step("rst_mul_run");
        end
        reset_n   = 1'b0;
        q.delete();
        cur       = mk(HD, HD, HD, 0, 0, 0, 0, 0);
        exp_ready = 1'b1;
        #1 check("async_rst", obs_vec(), exp_vec());
        step("rst_hold");
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst");

        // Randomized traffic; the source holds its instruction while refused.
        for (int i = 0; i < 600; i++) begin
            if (exp_ready) begin
                int r;
                r           = int'($urandom_range(0, 9));
                instr_valid = ($urandom_range(0, 3) != 0);
                opcode      = (r < 7) ? OP_W'(r) : OP_W'($urandom_range(7, 15));
                rep         = CNT_W'($urandom_range(0, 5));
            end
            y_lsb = 1'($urandom);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/microseq_controller.md
Name: microseq_controller

Overview:
Parametrised successor to the single-cycle CPU controller. It accepts instructions through a valid/ready handshake and drives registered control words to the X, Y and Z register blocks and to the ALU. Beyond the existing single-step opcodes, it sequences multi-cycle macro-ops: repeated add and shift-add multiply. It also reports busy, done and illegal-opcode status to the fetch logic.

Parameters:
OP_W, 4, opcode width (>=3)
CTL_W, 4, width of each register control word Tx/Ty/Tz
CNT_W, 4, width of the repeat-count field
MUL_ITER, 8, iterations of the MUL macro-op (>=1)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present on opcode/rep
instr_ready  output  1  controller can accept an instruction
opcode  input  OP_W  instruction opcode
rep  input  CNT_W  repeat count for REP_ADD (issues rep+1 adds)
y_lsb  input  1  current LSB of the Y register, sampled during MUL
Tx  output  CTL_W  X register control
Ty  output  CTL_W  Y register control
Tz  output  CTL_W  Z register control
Tula  output  1  ALU select: 0 = add, 1 = pass X
busy  output  1  macro-op in progress
done  output  1  one-cycle pulse on the final control word of any legal instruction
illegal  output  1  one-cycle pulse for an unrecognised opcode

Behaviour:
- Control codes (zero-extended to CTL_W): HOLD=0, LOAD=1, CLEAR=2, SHR=3.
- Idle word: Tx=Ty=Tz=HOLD, Tula=0.
- Reset (async, reset_n=0): state IDLE, idle word on all control outputs, busy=0, done=0, illegal=0, counters=0. Reset mid-macro-op aborts immediately; no further words are issued.
- All outputs are registered except instr_ready = (state==IDLE), which is combinational from state.
- Accept: instr_valid && instr_ready at a rising edge. The first control word appears at that same edge, so it is visible in the following cycle (latency 1). opcode, rep and y_lsb are only sampled at the points specified here.
- Each control word is valid for exactly one cycle. Outputs return to the idle word unless the next word follows. Unlike the previous controller, the last word is never held.
- Single-step opcodes: issue one word with done=1, stay in IDLE, and allow back-to-back accepts every cycle.
  - 0 CLEAR_ADD: Tx=LOAD, Ty=CLEAR, Tz=CLEAR, Tula=1
  - 1 ADD_LOAD: Tx=LOAD, Ty=LOAD, Tz=HOLD, Tula=0
  - 2 ADD: Tx=HOLD, Ty=LOAD, Tz=HOLD, Tula=0
  - 3 SHIFT_RIGHT: Tx=HOLD, Ty=SHR, Tz=HOLD, Tula=1
  - 4 DISP: Tx=CLEAR, Ty=CLEAR, Tz=LOAD, Tula=0
- 5 REP_ADD:
  - On accept, latch cnt=rep and issue an ADD word.
  - If cnt==0, done=1 and stay in IDLE.
  - Otherwise go to REP, where each cycle issues an ADD word and decrements cnt.
  - done and return to IDLE accompany the word issued when cnt reaches 0.
  - Total rep+1 ADD words in consecutive cycles; busy=1 while in REP.
- 6 MUL:
  - On accept, set it=MUL_ITER-1 and go to M_ADD. No word is issued at accept (idle word).
  - M_ADD: issue Tx=HOLD, Ty=(y_lsb sampled this cycle ? LOAD : HOLD), Tz=HOLD, Tula=0. Next state M_SHR.
  - M_SHR: issue Tx=HOLD, Ty=SHR, Tz=HOLD, Tula=1.
  - From M_SHR: if it==0, done=1 and go to IDLE; else decrement it and go to M_ADD.
  - Total 2*MUL_ITER words. busy=1 in M_ADD/M_SHR.
- Opcodes 7 and above (up to 2^OP_W-1): idle word, illegal=1 for one cycle, done=0, stay in IDLE.
- instr_valid while busy: not accepted; the instruction must be held stable by the source until ready.
- Counter width: it is sized ceil(log2(MUL_ITER)) with a minimum of 1. No wrap-around is reachable.

Test Plan:
- Reset during MUL iteration 3: assert reset_n=0 -> outputs idle within the same cycle (async); busy=0; after release, instr_ready=1 and no stray words.
- Back-to-back singles: opcodes 0,1,2,3,4 on 5 consecutive cycles -> words Tx/Ty/Tz/Tula = 1/2/2/1, 1/1/0/0, 0/1/0/0, 0/3/0/1, 2/2/1/0 on the next 5 cycles, done=1 on each, instr_ready constantly 1.
- REP_ADD rep=0 -> one ADD word, done=1, busy never 1. REP_ADD rep=3 -> 4 consecutive ADD words, busy=1 for 3 cycles, done only on the 4th, instr_ready=0 during busy.
- MUL with MUL_ITER=8, y_lsb pattern 1,0,1,1,0,0,0,1 over the M_ADD cycles -> 16 alternating words, Ty = LOAD/HOLD per pattern then SHR each time, done on the 16th word.
- Opcode 7 and 15 -> illegal pulses 1 cycle, idle word, done=0, next instruction accepted the following cycle.
- instr_valid held high with opcode=2 during a MUL -> not accepted until instr_ready rises; the ADD word follows exactly 1 cycle after acceptance.
